// File: rtl/main_ctrl_pkg.sv
// Shared constants for the multicycle RV32 main controller: state codes,
// opcodes, and the select/ALU encodings driven onto the datapath.
package main_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: what the FSM asks of the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format is a pure function of the opcode
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_main_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALU operation code.
module alu_decoder
  import main_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Pick the ALU operation; sub only for R-type with funct7[5] set
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle RV32 core. Outputs are decoded
// combinationally from the current state and instruction fields.
// Handshake: mem_ready high in a cycle means the memory completes the
// access presented that cycle; FETCH, MEMREAD and MEMWRITE hold until then.
// Optional: define MAIN_CTRL_ILLEGAL_TRAP_EN to send unknown opcodes to a
// sticky S_TRAP state and expose illegal_instr.
module multicycle_main_controller
  import main_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_retired,
  output logic [3:0] state_dbg
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  state_t     state_q, state_d;
  state_t     cur_state;
  logic [1:0] alu_op;
  logic       ir_we, pc_we, rf_we, mem_we, retire;

  // While reset is high the outputs look like FETCH; enables are masked below
  assign cur_state = reset ? S_FETCH : state_q;

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(ALUControl)
  );

  // Next-state and datapath control decode for the current state
  always_comb begin
    state_d   = S_FETCH;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    alu_op    = ALUOP_ADD;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    retire    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target PC+imm is computed here and lands in ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rf_we     = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_we  = 1'b1;
        retire  = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        pc_we   = Zero;
        retire  = 1'b1;
      end
      S_JAL: begin
        // PC <= ALUOut (target from DECODE); ALUResult = OldPC+4 for rd
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign ImmSrc        = imm_src_of(op);
  assign IRWrite       = ir_we  & ~reset;
  assign PCWrite       = pc_we  & ~reset;
  assign RegWrite      = rf_we  & ~reset;
  assign MemWrite      = mem_we & ~reset;
  assign instr_retired = retire & ~reset;
  assign state_dbg     = state_q;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_TRAP);
`endif

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
